// File: rtl/hazard_ctrl_sb_pkg.sv
// Shared types for the scoreboard hazard controller.
// cpu_types_pkg  : CPU-wide register-select type.
// diaosi_types_pkg : controller FSM state, forwarding select, scoreboard entry.
package cpu_types_pkg;
  localparam int REGBITS_W = 5;
  typedef logic [REGBITS_W-1:0] regbits_t;
endpackage

package diaosi_types_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MWAIT   = 2'd2
  } hstate_t;

  typedef logic [1:0] fwdsel_t;

  localparam fwdsel_t FWD_RF = 2'd0;  // operand from regfile via L2
  localparam fwdsel_t FWD_L3 = 2'd1;  // operand from EX/MEM result
  localparam fwdsel_t FWD_L4 = 2'd2;  // operand from MEM/WB writeback data

  typedef struct packed {
    logic     valid;
    regbits_t wsel;
    logic     load;
    logic     mem;
  } sb_entry_t;

  // The nearer (younger) producer wins over the older one.
  function automatic fwdsel_t fwd_pick(input logic near_hit, input logic far_hit);
    if (near_hit)     return FWD_L3;
    else if (far_hit) return FWD_L4;
    else              return FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_ctrl_sb_if.sv
// Signal bundle for the scoreboard hazard controller.
// hu = controller side, tb = environment/driver side.
interface hazard_ctrl_sb_if #(
  parameter int REG_W = 5
) (
  input logic CLK
);
  logic             nRST;
  logic             ihit;
  logic             dhit;
  logic             id_valid;
  logic [REG_W-1:0] rsel1;
  logic [REG_W-1:0] rsel2;
  logic [REG_W-1:0] wsel;
  logic             id_wen;
  logic             id_dren;
  logic             id_dwen;
  logic             branch_sel;
  logic             pc_en;
  logic [3:0]       en;
  logic [3:0]       flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       stall_st;

  modport hu (
    input  CLK, nRST, ihit, dhit, id_valid, rsel1, rsel2, wsel,
           id_wen, id_dren, id_dwen, branch_sel,
    output pc_en, en, flush, fwd_a, fwd_b, stall_st
  );

  modport tb (
    input  CLK, pc_en, en, flush, fwd_a, fwd_b, stall_st,
    output nRST, ihit, dhit, id_valid, rsel1, rsel2, wsel,
           id_wen, id_dren, id_dwen, branch_sel
  );
endinterface

// File: rtl/hazard_ctrl_sb_sb.sv
// hazard_sb: shift-register scoreboard of in-flight writers (S2 mirrors L2,
// S3 mirrors L3) plus per-operand match logic for the instruction in ID.
// S4 is not stored: the register file is write-through, so an L4 writer can
// never cause a hazard. The load flag is only consumed by the load-use check,
// so it is only kept when HAZARD_FWD_EN is defined.
module hazard_sb #(
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             l2_en,
  input  logic             l2_flush,
  input  logic             l3_en,
  input  logic             l3_flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] rsel1,
  input  logic [REG_W-1:0] rsel2,
  input  logic [REG_W-1:0] wsel,
  input  logic             id_wen,
  input  logic             id_dren,
  input  logic             id_dwen,
  output logic             m2a,
  output logic             m2b,
  output logic             m3a,
  output logic             m3b,
`ifdef HAZARD_FWD_EN
  output logic             s2_load,
`endif
  output logic             s3_mem
);
  logic             s2_valid, s2_mem, s3_valid;
  logic [REG_W-1:0] s2_wsel, s3_wsel;

  // Control bits: reset empties, a flushed latch takes a bubble, advance shifts.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      s2_valid <= 1'b0;
      s2_mem   <= 1'b0;
      s3_valid <= 1'b0;
      s3_mem   <= 1'b0;
`ifdef HAZARD_FWD_EN
      s2_load  <= 1'b0;
`endif
    end else begin
      if (l2_flush) begin
        s2_valid <= 1'b0;
        s2_mem   <= 1'b0;
`ifdef HAZARD_FWD_EN
        s2_load  <= 1'b0;
`endif
      end else if (l2_en) begin
        s2_valid <= id_valid & id_wen & (wsel != '0);
        s2_mem   <= id_valid & (id_dren | id_dwen);
`ifdef HAZARD_FWD_EN
        s2_load  <= id_valid & id_dren;
`endif
      end
      if (l3_flush) begin
        s3_valid <= 1'b0;
        s3_mem   <= 1'b0;
      end else if (l3_en) begin
        s3_valid <= s2_valid;
        s3_mem   <= s2_mem;
      end
    end
  end

  // Destination payload follows the latch enables; meaningless when invalid.
  always_ff @(posedge CLK) begin
    if (l2_en) s2_wsel <= wsel;
    if (l3_en) s3_wsel <= s2_wsel;
  end

  assign m2a = id_valid & s2_valid & (s2_wsel == rsel1);
  assign m2b = id_valid & s2_valid & (s2_wsel == rsel2);
  assign m3a = id_valid & s3_valid & (s3_wsel == rsel1);
  assign m3b = id_valid & s3_valid & (s3_wsel == rsel2);
endmodule

// File: rtl/hazard_ctrl_sb.sv
// hazard_ctrl_sb: scoreboard-based hazard controller for the 5-stage pipe.
// FSM sequences RAW and data-memory-wait stalls and drives per-latch
// enable/flush vectors (bit k-1 = Lk) plus pc_en.
// Optional feature macro HAZARD_FWD_EN: forwarding-aware (load-use only) RAW
// and registered EX forwarding selects; otherwise fwd_a/fwd_b are tied 0.
module hazard_ctrl_sb
  import diaosi_types_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int BR_STAGE = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             id_valid,
  input  logic [REG_W-1:0] rsel1,
  input  logic [REG_W-1:0] rsel2,
  input  logic [REG_W-1:0] wsel,
  input  logic             id_wen,
  input  logic             id_dren,
  input  logic             id_dwen,
  input  logic             branch_sel,
  output logic             pc_en,
  output logic [3:0]       en,
  output logic [3:0]       flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       stall_st
);
  // Branch squashes every latch up to and including the resolving one.
  localparam logic [3:0] BR_MASK = 4'((1 << BR_STAGE) - 1);

  hstate_t state, state_nx;
  logic    m2a, m2b, m3a, m3b, s3_mem, raw, mem_hold;
`ifdef HAZARD_FWD_EN
  logic    s2_load;
`endif

  hazard_sb #(.REG_W(REG_W)) u_sb (
    .CLK      (CLK),
    .nRST     (nRST),
    .l2_en    (en[1]),
    .l2_flush (flush[1]),
    .l3_en    (en[2]),
    .l3_flush (flush[2]),
    .id_valid (id_valid),
    .rsel1    (rsel1),
    .rsel2    (rsel2),
    .wsel     (wsel),
    .id_wen   (id_wen),
    .id_dren  (id_dren),
    .id_dwen  (id_dwen),
    .m2a      (m2a),
    .m2b      (m2b),
    .m3a      (m3a),
    .m3b      (m3b),
`ifdef HAZARD_FWD_EN
    .s2_load  (s2_load),
`endif
    .s3_mem   (s3_mem)
  );

`ifdef HAZARD_FWD_EN
  assign raw = (m2a | m2b) & s2_load;
`else
  assign raw = m2a | m2b | m3a | m3b;
`endif

  // In MWAIT only dhit releases the pipe; elsewhere a pending MEM access stalls.
  assign mem_hold = (state == MWAIT) ? !dhit : (s3_mem & !dhit);

  // Latch control and next state; the MWAIT exit cycle advances without a RAW re-check.
  always_comb begin
    pc_en    = 1'b0;
    en       = 4'b0000;
    flush    = 4'b0000;
    state_nx = state;
    if (!nRST) begin
      flush    = 4'b1111;
      state_nx = RUN;
    end else if (mem_hold) begin
      state_nx = MWAIT;
    end else if (branch_sel) begin
      pc_en    = 1'b1;
      en       = 4'b1111;
      flush    = BR_MASK;
      state_nx = RUN;
    end else if (raw && state != MWAIT) begin
      en       = 4'b1100;
      flush    = 4'b0010;
      state_nx = LDSTALL;
    end else begin
      pc_en    = ihit;
      en       = 4'b1111;
      flush    = {3'b000, !ihit};
      state_nx = RUN;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!nRST) state <= RUN;
    else       state <= state_nx;
  end

  assign stall_st = nRST ? 2'(state) : 2'd0;

`ifdef HAZARD_FWD_EN
  fwdsel_t fwd_a_r, fwd_b_r;

  // Forwarding selects captured as the ID instruction enters EX.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      fwd_a_r <= FWD_RF;
      fwd_b_r <= FWD_RF;
    end else if (flush[1]) begin
      fwd_a_r <= FWD_RF;
      fwd_b_r <= FWD_RF;
    end else if (en[1]) begin
      fwd_a_r <= fwd_pick(m2a & !s2_load, m3a);
      fwd_b_r <= fwd_pick(m2b & !s2_load, m3b);
    end
  end

  assign fwd_a = fwd_a_r;
  assign fwd_b = fwd_b_r;
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif
endmodule
